// File: rtl/otter_mmio_pkg.sv
// Shared OTTER MCU memory-mapped I/O definitions: peripheral addresses and
// the UART transmitter state type.
package otter_mmio_pkg;

    localparam logic [31:0] SWITCHES_AD  = 32'h1100_0000;
    localparam logic [31:0] LEDS_AD      = 32'h1100_0020;
    localparam logic [31:0] SSEG_AD      = 32'h1100_0040;
    localparam logic [31:0] UART_DATA_AD = 32'h1100_0060;
    localparam logic [31:0] UART_STAT_AD = 32'h1100_0064;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    // Clock cycles per line bit, rounded to nearest.
    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. A push into a full FIFO is still
// accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic                         push_ok_o,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o    = (count_q == CntW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign do_pop    = pop_i && !empty_o;
    assign do_push   = push_i && (!full_o || do_pop);
    assign push_ok_o = do_push;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter for the OTTER IOBUS: stores queue bytes
// in a FIFO, a status word is readable combinationally, TX_DONE marks drain.
module uart_tx_mmio
    import otter_mmio_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] DATA_AD    = UART_DATA_AD,
    parameter logic [31:0] STAT_AD    = UART_STAT_AD
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_RD,
    output logic        TX,
    output logic        TX_DONE
);

    localparam int unsigned Div    = baud_div(CLK_HZ, BAUD);
    localparam int unsigned CntW   = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [CntW-1:0] DivMax = CntW'(Div - 1);
    localparam int unsigned FcntW  = $clog2(FIFO_DEPTH + 1);

    uart_state_t     state_q, state_d;
    logic [CntW-1:0] baud_q, baud_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      idx_q, idx_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;

    logic             data_wr, stat_wr;
    logic             fifo_pop, push_ok;
    logic             fifo_full, fifo_empty;
    logic [7:0]       fifo_rdata;
    logic [FcntW-1:0] fifo_count;
    logic             baud_end, busy;
    logic             unused_store_bits;

    assign data_wr           = IOBUS_WR && (IOBUS_ADDR == DATA_AD);
    assign stat_wr           = IOBUS_WR && (IOBUS_ADDR == STAT_AD);
    assign baud_end          = (baud_q == DivMax);
    assign busy              = (state_q != IDLE) || (fifo_count != '0);
    assign unused_store_bits = ^IOBUS_OUT[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (CLK),
        .rst_i     (RST),
        .push_i    (data_wr),
        .wdata_i   (IOBUS_OUT[7:0]),
        .pop_i     (fifo_pop),
        .push_ok_o (push_ok),
        .rdata_o   (fifo_rdata),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    // Set beats clear; the two cannot coincide on a single-address bus anyway.
    always_comb begin
        ovf_d = ovf_q;
        if (stat_wr && IOBUS_OUT[2]) begin
            ovf_d = 1'b0;
        end
        if (data_wr && !push_ok) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
        fifo_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    baud_d   = '0;
                    tx_d     = 1'b0;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + 3'd1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit, no idle gap.
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        tx_d     = 1'b0;
                        state_d  = START;
                    end else begin
                        tx_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            baud_q  <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        IOBUS_RD = '0;
        if (IOBUS_ADDR == STAT_AD) begin
            IOBUS_RD = {29'b0, ovf_q, fifo_full, busy};
        end
    end

    assign TX      = tx_q;
    assign TX_DONE = done_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Randomised bench for uart_tx_mmio, checked against a frame-level queue model
// of the transmitter (DIV = 10).
module tb_uart_tx_mmio;

    localparam int unsigned CLK_HZ = 1000;
    localparam int unsigned BAUD   = 100;
    localparam int          DEPTH  = 8;
    localparam int          DIV    = 10;
    localparam int          FRAME  = 10 * DIV;
    localparam logic [31:0] DATA_AD = 32'h1100_0060;
    localparam logic [31:0] STAT_AD = 32'h1100_0064;
    localparam logic [31:0] SW_AD   = 32'h1100_0000;
    localparam logic [31:0] LED_AD  = 32'h1100_0020;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] IOBUS_ADDR = '0;
    logic [31:0] IOBUS_OUT = '0;
    logic        IOBUS_WR = 1'b0;
    logic [31:0] IOBUS_RD;
    logic        TX;
    logic        TX_DONE;

    int checks = 0;
    int errors = 0;

    int          sched_cyc[$];
    logic [7:0]  sched_dat[$];
    int          clr_cyc = -1;
    logic        obs_tx[$], obs_done[$], exp_tx[$], exp_done[$];
    logic [31:0] obs_rd[$], exp_rd[$];

    uart_tx_mmio #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH),
        .DATA_AD    (DATA_AD),
        .STAT_AD    (STAT_AD)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .IOBUS_RD   (IOBUS_RD),
        .TX         (TX),
        .TX_DONE    (TX_DONE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int sched_idx(input int s);
        foreach (sched_cyc[i]) if (sched_cyc[i] == s) return i;
        return -1;
    endfunction

    // Sample s sees the state after clock edge s-1; stimulus driven at sample s
    // is taken at edge s. A popped byte at edge p occupies samples p+1..p+FRAME.
    task automatic build_model(input int n);
        logic [7:0] q[$];
        int         next_free = 0;
        int         cur_p = -1;
        logic [9:0] frame = '1;
        logic       ovf = 1'b0;
        logic       done_flag = 1'b0;
        logic       pop, busy;
        int         k;
        exp_tx.delete();
        exp_done.delete();
        exp_rd.delete();
        for (int s = 0; s < n; s++) begin
            if (cur_p >= 0 && s - 1 >= cur_p && s - 1 < cur_p + FRAME)
                exp_tx.push_back(frame[(s - 1 - cur_p) / DIV]);
            else
                exp_tx.push_back(1'b1);
            exp_done.push_back(done_flag);
            busy = (q.size() != 0) || (cur_p >= 0 && s - 1 < cur_p + FRAME);
            k = sched_idx(s);
            if (k >= 0) exp_rd.push_back(32'd0);
            else exp_rd.push_back({29'd0, ovf, (q.size() == DEPTH), busy});
            pop = (q.size() != 0) && (s >= next_free);
            done_flag = (cur_p >= 0) && (s == cur_p + FRAME) && !pop;
            if (pop) begin
                frame = {1'b1, q.pop_front(), 1'b0};
                cur_p = s;
                next_free = s + FRAME;
            end
            if (k >= 0) begin
                if (q.size() < DEPTH) q.push_back(sched_dat[k]);
                else ovf = 1'b1;
            end
            if (s == clr_cyc) ovf = 1'b0;
        end
    endtask

    task automatic capture(input int n);
        int k;
        obs_tx.delete();
        obs_done.delete();
        obs_rd.delete();
        for (int s = 0; s < n; s++) begin
            @(negedge CLK);
            obs_tx.push_back(TX);
            obs_done.push_back(TX_DONE);
            k = sched_idx(s);
            if (k >= 0) begin
                IOBUS_ADDR = DATA_AD;
                IOBUS_OUT = $urandom;
                IOBUS_OUT[7:0] = sched_dat[k];
                IOBUS_WR = 1'b1;
            end else if (s == clr_cyc) begin
                IOBUS_ADDR = STAT_AD;
                IOBUS_OUT = $urandom | 32'h4;
                IOBUS_WR = 1'b1;
            end else begin
                IOBUS_ADDR = STAT_AD;
                IOBUS_OUT = $urandom;
                IOBUS_WR = 1'b0;
            end
            #1;
            obs_rd.push_back(IOBUS_RD);
        end
        IOBUS_WR = 1'b0;
        IOBUS_ADDR = STAT_AD;
    endtask

    function automatic int first_bad_tx();
        foreach (exp_tx[i]) if (obs_tx[i] !== exp_tx[i]) return i;
        return -1;
    endfunction

    function automatic int first_bad_done();
        foreach (exp_done[i]) if (obs_done[i] !== exp_done[i]) return i;
        return -1;
    endfunction

    function automatic int first_bad_rd();
        foreach (exp_rd[i]) if (obs_rd[i] !== exp_rd[i]) return i;
        return -1;
    endfunction

    function automatic int done_pulses();
        int c = 0;
        foreach (obs_done[i]) if (obs_done[i] === 1'b1) c++;
        return c;
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        IOBUS_WR = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        clr_cyc = -1;
        sched_cyc.delete();
        sched_dat.delete();
    endtask

    task automatic sched_consecutive(input int nbytes);
        sched_cyc.delete();
        sched_dat.delete();
        for (int i = 0; i < nbytes; i++) begin
            sched_cyc.push_back(i);
            sched_dat.push_back(8'($urandom));
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        IOBUS_ADDR = STAT_AD;
        #1;
        checks++;
        if (TX !== 1'b1) begin errors++; $display("FAIL reset_tx: TX=%b expected 1", TX); end
        checks++;
        if (TX_DONE !== 1'b0) begin errors++; $display("FAIL reset_done: TX_DONE=%b expected 0", TX_DONE); end
        checks++;
        if (IOBUS_RD !== 32'd0) begin errors++; $display("FAIL reset_stat: RD=%h expected 0", IOBUS_RD); end
        RST = 1'b0;
        @(negedge CLK);
        #1;
        checks++;
        if (TX !== 1'b1 || IOBUS_RD !== 32'd0)
            begin errors++; $display("FAIL post_reset: TX=%b RD=%h expected 1 / 0", TX, IOBUS_RD); end
    endtask

    task automatic test_single_byte();
        int d;
        for (int it = 0; it < 2; it++) begin
            do_reset();
            sched_cyc.push_back(0);
            sched_dat.push_back(it == 0 ? 8'h55 : 8'($urandom));
            build_model(112);
            capture(112);
            checks++; d = first_bad_tx();
            if (d != -1) begin errors++;
                $display("FAIL single_tx: byte %h sample %0d TX=%b expected %b", sched_dat[0], d, obs_tx[d], exp_tx[d]); end
            checks++; d = first_bad_done();
            if (d != -1) begin errors++;
                $display("FAIL single_done: sample %0d TX_DONE=%b expected %b", d, obs_done[d], exp_done[d]); end
            checks++; d = first_bad_rd();
            if (d != -1) begin errors++;
                $display("FAIL single_rd: sample %0d RD=%h expected %h", d, obs_rd[d], exp_rd[d]); end
            checks++;
            if (obs_done[102] !== 1'b1 || done_pulses() != 1) begin errors++;
                $display("FAIL single_done_pos: done@102=%b pulses=%0d expected 1 and 1", obs_done[102], done_pulses()); end
        end
    endtask

    task automatic test_back_to_back();
        int d;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            sched_cyc.push_back(i);
            sched_dat.push_back(8'(i + 1));
        end
        build_model(312);
        capture(312);
        checks++; d = first_bad_tx();
        if (d != -1) begin errors++;
            $display("FAIL b2b_tx: sample %0d TX=%b expected %b", d, obs_tx[d], exp_tx[d]); end
        checks++; d = first_bad_rd();
        if (d != -1) begin errors++;
            $display("FAIL b2b_rd: sample %0d RD=%h expected %h", d, obs_rd[d], exp_rd[d]); end
        checks++;
        if (obs_done[302] !== 1'b1 || done_pulses() != 1) begin errors++;
            $display("FAIL b2b_done: done@302=%b pulses=%0d expected 1 and 1", obs_done[302], done_pulses()); end
    endtask

    task automatic test_overflow();
        int d;
        do_reset();
        sched_consecutive(10);
        clr_cyc = 10;
        build_model(910);
        capture(910);
        checks++; d = first_bad_tx();
        if (d != -1) begin errors++;
            $display("FAIL ovf_tx: sample %0d TX=%b expected %b", d, obs_tx[d], exp_tx[d]); end
        checks++; d = first_bad_rd();
        if (d != -1) begin errors++;
            $display("FAIL ovf_rd: sample %0d RD=%h expected %h", d, obs_rd[d], exp_rd[d]); end
        checks++;
        if (obs_rd[10] !== 32'd7) begin errors++; $display("FAIL ovf_stat_set: RD=%h expected 7", obs_rd[10]); end
        checks++;
        if (obs_rd[11] !== 32'd3) begin errors++; $display("FAIL ovf_stat_clr: RD=%h expected 3", obs_rd[11]); end
        checks++;
        if (obs_done[902] !== 1'b1 || done_pulses() != 1) begin errors++;
            $display("FAIL ovf_done: done@902=%b pulses=%0d expected 1 and 1", obs_done[902], done_pulses()); end
        clr_cyc = -1;
    endtask

    task automatic test_push_pop_full();
        int d;
        do_reset();
        sched_consecutive(9);
        sched_cyc.push_back(1 + FRAME);
        sched_dat.push_back(8'($urandom));
        build_model(1010);
        capture(1010);
        checks++; d = first_bad_tx();
        if (d != -1) begin errors++;
            $display("FAIL full_tx: sample %0d TX=%b expected %b", d, obs_tx[d], exp_tx[d]); end
        checks++; d = first_bad_rd();
        if (d != -1) begin errors++;
            $display("FAIL full_rd: sample %0d RD=%h expected %h", d, obs_rd[d], exp_rd[d]); end
        checks++;
        if (obs_rd[100] !== 32'd3 || obs_rd[102] !== 32'd3) begin errors++;
            $display("FAIL full_stat: RD@100=%h RD@102=%h expected 3 and 3", obs_rd[100], obs_rd[102]); end
        checks++;
        if (obs_done[1002] !== 1'b1 || done_pulses() != 1) begin errors++;
            $display("FAIL full_done: done@1002=%b pulses=%0d expected 1 and 1", obs_done[1002], done_pulses()); end
    endtask

    task automatic test_random();
        int d, cnt, cyc, n;
        for (int it = 0; it < 3; it++) begin
            do_reset();
            cnt = $urandom_range(1, 12);
            cyc = $urandom_range(0, 3);
            for (int i = 0; i < cnt; i++) begin
                sched_cyc.push_back(cyc);
                sched_dat.push_back(8'($urandom));
                cyc += $urandom_range(1, 40);
            end
            n = cyc + FRAME * cnt + 20;
            build_model(n);
            capture(n);
            checks++; d = first_bad_tx();
            if (d != -1) begin errors++;
                $display("FAIL rand_tx: iter %0d sample %0d TX=%b expected %b", it, d, obs_tx[d], exp_tx[d]); end
            checks++; d = first_bad_done();
            if (d != -1) begin errors++;
                $display("FAIL rand_done: iter %0d sample %0d TX_DONE=%b expected %b", it, d, obs_done[d], exp_done[d]); end
            checks++; d = first_bad_rd();
            if (d != -1) begin errors++;
                $display("FAIL rand_rd: iter %0d sample %0d RD=%h expected %h", it, d, obs_rd[d], exp_rd[d]); end
        end
    endtask

    task automatic test_reset_mid();
        int d, bad;
        do_reset();
        sched_consecutive(1);
        build_model(45);
        capture(45);
        checks++; d = first_bad_tx();
        if (d != -1) begin errors++;
            $display("FAIL mid_pre_tx: sample %0d TX=%b expected %b", d, obs_tx[d], exp_tx[d]); end
        // Now inside data bit 3; reset lands between clock edges.
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if (TX !== 1'b1 || TX_DONE !== 1'b0 || IOBUS_RD !== 32'd0) begin errors++;
            $display("FAIL mid_reset: TX=%b TX_DONE=%b RD=%h expected 1 0 0", TX, TX_DONE, IOBUS_RD); end
        @(negedge CLK);
        RST = 1'b0;
        bad = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge CLK);
            if (TX !== 1'b1 || TX_DONE !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL mid_quiet: %0d active cycles expected 0", bad); end
        sched_consecutive(1);
        build_model(112);
        capture(112);
        checks++; d = first_bad_tx();
        if (d != -1) begin errors++;
            $display("FAIL mid_after_tx: sample %0d TX=%b expected %b", d, obs_tx[d], exp_tx[d]); end
        checks++; d = first_bad_done();
        if (d != -1) begin errors++;
            $display("FAIL mid_after_done: sample %0d TX_DONE=%b expected %b", d, obs_done[d], exp_done[d]); end
    endtask

    task automatic test_read_decode();
        logic seen;
        do_reset();
        @(negedge CLK);
        IOBUS_ADDR = SW_AD;
        #1;
        checks++;
        if (IOBUS_RD !== 32'd0) begin errors++; $display("FAIL rd_switches_idle: RD=%h expected 0", IOBUS_RD); end
        IOBUS_ADDR = STAT_AD;
        #1;
        checks++;
        if (IOBUS_RD !== 32'd0) begin errors++; $display("FAIL rd_stat_idle: RD=%h expected 0", IOBUS_RD); end
        @(negedge CLK);
        IOBUS_ADDR = DATA_AD;
        IOBUS_OUT = $urandom;
        IOBUS_WR = 1'b1;
        @(negedge CLK);
        IOBUS_WR = 1'b0;
        repeat (5) @(negedge CLK);
        IOBUS_ADDR = LED_AD;
        #1;
        checks++;
        if (IOBUS_RD !== 32'd0) begin errors++; $display("FAIL rd_leds_busy: RD=%h expected 0", IOBUS_RD); end
        IOBUS_ADDR = STAT_AD;
        #1;
        checks++;
        if (IOBUS_RD !== 32'd1) begin errors++; $display("FAIL rd_stat_busy: RD=%h expected 1", IOBUS_RD); end
        seen = 1'b0;
        for (int i = 0; i < 150 && !seen; i++) begin
            @(negedge CLK);
            if (TX_DONE === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b1) begin errors++; $display("FAIL rd_done_wait: seen=%b expected 1", seen); end
        #1;
        checks++;
        if (IOBUS_RD !== 32'd0) begin errors++; $display("FAIL rd_stat_drained: RD=%h expected 0", IOBUS_RD); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_push_pop_full();
        test_random();
        test_reset_mid();
        test_read_decode();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
